// File: rtl/sram_bus_test_if.sv
// SRAM request bus between the self-test block and the SRAM controller.
interface sram_bus_test_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 20
);
    logic              mem;
    logic              rw;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data2ram;
    logic [DATA_W-1:0] data2fpga;

    modport master (output mem, rw, addr, data2ram, input ready, data2fpga);
    modport slave  (input mem, rw, addr, data2ram, output ready, data2fpga);
endinterface

// File: rtl/sram_bus_test.sv
// SRAM bus self-test: walking-ones/zeros data-bus test at one address,
// then an optional address-bus test on power-of-two offsets. The first
// mismatch is captured for debug readout.
module sram_bus_test #(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] TEST_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    sram_bus_test_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              result,
    output logic [1:0]        fail_stage,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);
    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam int IW = (ADDR_W > 2) ? $clog2(ADDR_W) : 1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_D_WR   = 4'd1;
    localparam logic [3:0] S_D_RD   = 4'd2;
    localparam logic [3:0] S_D_CMP  = 4'd3;
    localparam logic [3:0] S_A_WRB  = 4'd4;
    localparam logic [3:0] S_A_WRO  = 4'd5;
    localparam logic [3:0] S_A_RDO  = 4'd6;
    localparam logic [3:0] S_A_CMPO = 4'd7;
    localparam logic [3:0] S_A_RDB  = 4'd8;
    localparam logic [3:0] S_A_CMPB = 4'd9;
    localparam logic [3:0] S_DONE   = 4'd10;

    localparam logic [DATA_W-1:0] PAT  = {DATA_W/2{2'b10}};
    localparam logic [DATA_W-1:0] ANTI = ~PAT;

    logic [3:0]        state;
    logic [BW-1:0]     bit_idx;
    logic              pass;
    logic [IW-1:0]     idx;
    logic [1:0]        mode_snap;
    logic [DATA_W-1:0] walk, d_pat;
    logic [ADDR_W-1:0] off_addr;
    logic              issue;

    assign walk     = DATA_W'(1) << bit_idx;
    assign d_pat    = pass ? ~walk : walk;
    assign off_addr = TEST_ADDR ^ (ADDR_W'(1) << idx);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);

    // Bus request decode: a request is only presented while the controller is ready.
    always_comb begin
        issue        = 1'b0;
        bus.rw       = 1'b1;
        bus.addr     = TEST_ADDR;
        bus.data2ram = '0;
        case (state)
            S_D_WR:  begin issue = 1'b1; bus.rw = 1'b0; bus.data2ram = d_pat; end
            S_D_RD:  issue = 1'b1;
            S_A_WRB: begin issue = 1'b1; bus.rw = 1'b0; bus.data2ram = ANTI; end
            S_A_WRO: begin issue = 1'b1; bus.rw = 1'b0; bus.addr = off_addr; bus.data2ram = PAT; end
            S_A_RDO: begin issue = 1'b1; bus.addr = off_addr; end
            S_A_RDB: issue = 1'b1;
            default: ;
        endcase
        bus.mem = issue & bus.ready;
    end

    // Test sequencer: every issuing/compare state waits for ready before advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_idx    <= '0;
            pass       <= 1'b0;
            idx        <= '0;
            mode_snap  <= 2'd0;
            result     <= 1'b0;
            fail_stage <= 2'd0;
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else begin
            case (state)
                S_IDLE: if (en) begin
                    result     <= 1'b0;
                    fail_stage <= 2'd0;
                    fail_addr  <= '0;
                    fail_exp   <= '0;
                    fail_got   <= '0;
                    bit_idx    <= '0;
                    pass       <= 1'b0;
                    idx        <= '0;
                    mode_snap  <= mode;
                    state      <= (mode == 2'd1) ? S_A_WRB : S_D_WR;
                end
                S_D_WR: if (bus.ready) state <= S_D_RD;
                S_D_RD: if (bus.ready) state <= S_D_CMP;
                S_D_CMP: if (bus.ready) begin
                    if (bus.data2fpga != d_pat) begin
                        fail_stage <= 2'd1;
                        fail_addr  <= TEST_ADDR;
                        fail_exp   <= d_pat;
                        fail_got   <= bus.data2fpga;
                        state      <= S_DONE;
                    end else if (bit_idx != BW'(DATA_W-1)) begin
                        bit_idx <= bit_idx + 1'b1;
                        state   <= S_D_WR;
                    end else if (!pass) begin
                        pass    <= 1'b1;
                        bit_idx <= '0;
                        state   <= S_D_WR;
                    end else if (mode_snap == 2'd0) begin
                        result <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_A_WRB;
                    end
                end
                S_A_WRB: if (bus.ready) state <= S_A_WRO;
                S_A_WRO: if (bus.ready) begin
                    if (idx == IW'(ADDR_W-1)) begin
                        idx   <= '0;
                        state <= S_A_RDO;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_A_RDO: if (bus.ready) state <= S_A_CMPO;
                S_A_CMPO: if (bus.ready) begin
                    if (bus.data2fpga != PAT) begin
                        fail_stage <= 2'd2;
                        fail_addr  <= off_addr;
                        fail_exp   <= PAT;
                        fail_got   <= bus.data2fpga;
                        state      <= S_DONE;
                    end else if (idx == IW'(ADDR_W-1)) begin
                        idx   <= '0;
                        state <= S_A_RDB;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_A_RDO;
                    end
                end
                S_A_RDB: if (bus.ready) state <= S_A_CMPB;
                S_A_CMPB: if (bus.ready) begin
                    if (bus.data2fpga != ANTI) begin
                        fail_stage <= 2'd3;
                        fail_addr  <= TEST_ADDR;
                        fail_exp   <= ANTI;
                        fail_got   <= bus.data2fpga;
                    end else begin
                        result <= 1'b1;
                    end
                    state <= S_DONE;
                end
                S_DONE: if (!en) state <= S_IDLE;
                default: begin
                    result <= 1'b0;
                    state  <= S_DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bus_test.sv
// Bench for sram_bus_test: behavioural SRAM with injectable faults, plus a
// reference model that derives the expected op stream and outcome directly
// from the test algorithm.
module tb_sram_bus_test;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam logic [AW-1:0] TA   = '0;
    localparam logic [DW-1:0] PAT  = 8'hAA;
    localparam logic [DW-1:0] ANTI = 8'h55;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    logic clk = 0, rst_n = 0, en = 0;
    logic [1:0] mode = 0;
    logic busy, done, result;
    logic [1:0] fail_stage;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_got;

    sram_bus_test_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    sram_bus_test #(.DATA_W(DW), .ADDR_W(AW), .TEST_ADDR(TA)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .bus(bif.master),
        .busy(busy), .done(done), .result(result), .fail_stage(fail_stage),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got)
    );

    always #10 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int fault = 0;      // 0 ideal, 1 data bit3 sa0, 2 addr bit4 sa0, 3 addr4/5 OR short, 4 writes with a[7] lost
    bit rand_ready = 0;
    int n_rdy = 0;
    logic [DW-1:0] rd_q = '0;
    logic [DW-1:0] ram  [int];
    logic [DW-1:0] mref [int];
    op_t obs[$], exp_ops[$];
    int  e_cyc;
    logic e_result;
    logic [1:0] e_stage;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_exp, e_got;

    assign bif.data2fpga = rd_q;

    function automatic logic [AW-1:0] phys(input logic [AW-1:0] a);
        if (fault == 2) return a & ~20'h10;
        if (fault == 3 && (a[4] | a[5])) return a | 20'h30;
        return a;
    endfunction

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
        return (fault == 1) ? (d & 8'hF7) : d;
    endfunction

    // SRAM behaviour plus bus monitor
    always @(posedge clk) begin
        if (bif.mem) begin
            if (!bif.ready) n_rdy++;
            obs.push_back({bif.rw, bif.addr, bif.rw ? 8'h00 : bif.data2ram});
            if (!bif.rw) begin
                if (!(fault == 4 && bif.addr[7])) ram[int'(phys(bif.addr))] = stored(bif.data2ram);
            end else begin
                rd_q <= ram.exists(int'(phys(bif.addr))) ? ram[int'(phys(bif.addr))] : 8'h00;
            end
        end
    end

    initial begin
        bif.ready = 1'b1;
        forever begin
            @(negedge clk);
            bif.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: algorithm-level walk over the test, against its own memory.
    task automatic ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_ops.push_back({1'b0, a, d});
        e_cyc += 1;
        if (!(fault == 4 && a[7])) mref[int'(phys(a))] = stored(d);
    endtask

    task automatic ref_rd(input logic [AW-1:0] a, output logic [DW-1:0] got);
        exp_ops.push_back({1'b1, a, 8'h00});
        e_cyc += 2;
        got = mref.exists(int'(phys(a))) ? mref[int'(phys(a))] : 8'h00;
    endtask

    task automatic build_expected(input logic [1:0] md);
        logic [DW-1:0] d, got;
        logic [AW-1:0] oa;
        bit stop;
        mref.delete(); exp_ops.delete();
        e_cyc = 0; e_result = 0; e_stage = 0; e_addr = 0; e_exp = 0; e_got = 0; stop = 0;
        if (md != 2'd1) begin
            for (int p = 0; p < 2 && !stop; p++)
                for (int b = 0; b < DW && !stop; b++) begin
                    d = 8'(1 << b);
                    if (p == 1) d = ~d;
                    ref_wr(TA, d);
                    ref_rd(TA, got);
                    if (got != d) begin
                        stop = 1; e_stage = 1; e_addr = TA; e_exp = d; e_got = got;
                    end
                end
        end
        if (!stop && md == 2'd0) e_result = 1;
        if (!stop && md != 2'd0) begin
            ref_wr(TA, ANTI);
            for (int i = 0; i < AW; i++) ref_wr(TA ^ (20'd1 << i), PAT);
            for (int i = 0; i < AW && !stop; i++) begin
                oa = TA ^ (20'd1 << i);
                ref_rd(oa, got);
                if (got != PAT) begin
                    stop = 1; e_stage = 2; e_addr = oa; e_exp = PAT; e_got = got;
                end
            end
            if (!stop) begin
                ref_rd(TA, got);
                if (got != ANTI) begin
                    e_stage = 3; e_addr = TA; e_exp = ANTI; e_got = got;
                end else e_result = 1;
            end
        end
    endtask

    // Starts a run and waits for done; leaves en high. Returns processing cycles.
    task automatic start_run(input logic [1:0] md, input int flt, input bit rr, output int cyc, output bit tmo);
        fault = flt; mode = md;
        build_expected(md);
        ram.delete(); obs.delete(); n_rdy = 0; rd_q = '0; rand_ready = rr;
        @(negedge clk) en = 1;
        @(posedge clk);
        cyc = 0; tmo = 1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (done) begin tmo = 0; break; end
            @(posedge clk);
            cyc++;
        end
        rand_ready = 0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({bif.mem, bif.rw, bif.addr, bif.data2ram} !== {1'b0, 1'b1, TA, 8'h00}) begin
            n_fail++; $display("FAIL reset_bus: got mem=%b rw=%b addr=%h d=%h want 0 1 %h 00", bif.mem, bif.rw, bif.addr, bif.data2ram, TA);
        end
        n_tests++;
        if ({busy, done, result, fail_stage, fail_addr, fail_exp, fail_got} !== '0) begin
            n_fail++; $display("FAIL reset_status: busy=%b done=%b result=%b stage=%0d fa=%h fe=%h fg=%h want all 0",
                               busy, done, result, fail_stage, fail_addr, fail_exp, fail_got);
        end
    endtask

    task automatic test_scenario(input string name, input logic [1:0] md, input int flt, input bit rr);
        int cyc, mism;
        bit tmo;
        start_run(md, flt, rr, cyc, tmo);
        n_tests++;
        if (tmo) begin n_fail++; $display("FAIL %s_timeout: done never rose", name); end
        n_tests++;
        if (!rr && cyc != e_cyc) begin n_fail++; $display("FAIL %s_cycles: got %0d want %0d", name, cyc, e_cyc); end
        n_tests++;
        if ({result, fail_stage, busy} !== {e_result, e_stage, 1'b0}) begin
            n_fail++; $display("FAIL %s_result: result=%b stage=%0d busy=%b want %b %0d 0", name, result, fail_stage, busy, e_result, e_stage);
        end
        n_tests++;
        if ({fail_addr, fail_exp, fail_got} !== {e_addr, e_exp, e_got}) begin
            n_fail++; $display("FAIL %s_capture: addr=%h exp=%h got=%h want %h %h %h", name, fail_addr, fail_exp, fail_got, e_addr, e_exp, e_got);
        end
        mism = (obs.size() != exp_ops.size()) ? 1 : 0;
        for (int i = 0; i < obs.size() && i < exp_ops.size(); i++)
            if (obs[i] !== exp_ops[i]) begin
                if (mism == 0) $display("  %s op %0d: got %h want %h", name, i, obs[i], exp_ops[i]);
                mism++;
            end
        n_tests++;
        if (mism != 0) begin n_fail++; $display("FAIL %s_ops: %0d ops seen, %0d expected, %0d differ", name, obs.size(), exp_ops.size(), mism); end
        n_tests++;
        if (n_rdy != 0) begin n_fail++; $display("FAIL %s_mem_not_ready: %0d requests with ready=0, want 0", name, n_rdy); end
        @(negedge clk) en = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k;
        fault = 0; mode = 2'd1; obs.delete(); ram.delete();
        @(negedge clk) en = 1;
        for (k = 0; k < 200 && obs.size() < 4; k++) @(negedge clk);
        n_tests++;
        if (k >= 200 || !bif.mem) begin n_fail++; $display("FAIL rstmid_setup: ops=%0d mem=%b, want >=4 ops and mem=1", obs.size(), bif.mem); end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({bif.mem, busy, done, bif.addr, bif.rw, bif.data2ram} !== {1'b0, 1'b0, 1'b0, TA, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL rstmid_outputs: mem=%b busy=%b done=%b addr=%h rw=%b d=%h want 0 0 0 %h 1 00",
                               bif.mem, busy, done, bif.addr, bif.rw, bif.data2ram, TA);
        end
        en = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_reset();
        test_scenario("rerun", 2'd2, 0, 0);
    endtask

    task automatic test_done_hold();
        int cyc, nops;
        bit tmo;
        start_run(2'd0, 0, 0, cyc, tmo);
        nops = obs.size();
        repeat (5) @(negedge clk);
        n_tests++;
        if (tmo || done !== 1'b1 || busy !== 1'b0 || obs.size() != nops) begin
            n_fail++; $display("FAIL hold_done: done=%b busy=%b extra_ops=%0d want 1 0 0", done, busy, obs.size() - nops);
        end
        en = 0;
        @(negedge clk);
        n_tests++;
        if ({done, result} !== 2'b01) begin n_fail++; $display("FAIL hold_idle: done=%b result=%b want 0 1", done, result); end
        en = 1;
        @(negedge clk);
        n_tests++;
        if ({busy, bif.rw, bif.data2ram} !== {1'b1, 1'b0, 8'h01}) begin
            n_fail++; $display("FAIL hold_restart: busy=%b rw=%b d=%h want 1 0 01", busy, bif.rw, bif.data2ram);
        end
        rst_n = 0; en = 0;
        @(negedge clk) rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1;
        @(negedge clk);
        test_reset();
        test_scenario("data_ideal", 2'd0, 0, 0);
        test_scenario("data_bit3", 2'd0, 1, 0);
        test_scenario("addr_ideal", 2'd1, 0, 0);
        test_scenario("addr_bit4", 2'd1, 2, 0);
        test_scenario("addr_short45", 2'd1, 3, 0);
        test_scenario("addr_lostwr", 2'd3, 4, 0);
        test_scenario("rand_ready", 2'd2, 0, 1);
        test_scenario("rand_ready_f", 2'd2, 4, 1);
        test_reset_mid();
        test_done_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
